// File: rtl/sram_rd_pkg.sv
// sram_rd_pkg: shared widths, FIFO depth and FSM state encoding for the
// SRAM read-port streamer (sram_rd_streamer, sram_rd_fifo2).
package sram_rd_pkg;

  localparam int unsigned AW_DEF     = 8;   // SRAM word address width
  localparam int unsigned DW_DEF     = 32;  // SRAM data width
  localparam int unsigned LW_DEF     = 9;   // burst length width
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;   // holds 0..FIFO_DEPTH

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/sram_rd_fifo2.sv
// sram_rd_fifo2: 2-entry synchronous FIFO holding captured SRAM read data.
// Ports:
//   clk, rst        clock, async active-high reset (clears storage)
//   push_i, data_i  write one entry (caller guarantees not full unless popping)
//   pop_i           drop the head entry (caller guarantees not empty)
//   head_o          oldest entry, stable until popped
//   count_o         number of stored entries (0..2)
module sram_rd_fifo2
  import sram_rd_pkg::*;
#(
  parameter int unsigned W = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage, pointers and count. On a full FIFO a simultaneous push lands in
  // the slot being popped, so ordering is preserved and count stays at 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_i && !push_i) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: burst reader for the read-only port of the 1RW1R SRAM.
// Accepts (cmd_addr, cmd_len), issues one read per cycle on the active-low
// read port, captures the 1-cycle-latency data into a 2-entry FIFO and
// presents it as a valid/ready stream with full backpressure.
// Optional macro SRAM_RD_LAST_EN adds out_last, stored with each FIFO entry.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cmd_addr/cmd_len/cmd_valid/ready burst command handshake (len 0 legal)
//   sram_csb/sram_addr/sram_dout     SRAM read port
//   out_data/out_valid/out_ready     output stream (out_last if enabled)
//   busy                             burst in progress
//   done                             pulse on final pop or zero-length accept
module sram_rd_streamer
  import sram_rd_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic          sram_csb,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_dout,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef SRAM_RD_LAST_EN
  output logic          out_last,
`endif
  output logic          busy,
  output logic          done
);

`ifdef SRAM_RD_LAST_EN
  localparam int unsigned FW = DW + 1;
`else
  localparam int unsigned FW = DW;
`endif

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LW-1:0]    rem_q, rem_d;        // reads still to issue
  logic [LW-1:0]    pop_rem_q, pop_rem_d; // words still to hand downstream
  logic             pend_q;               // read issued last cycle
  logic             zero_done_q, zero_done_d;
  logic             issue;
  logic             pop;
  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] fifo_count;
  logic [FW-1:0]    fifo_in;
  logic [FW-1:0]    fifo_head;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      pop_rem_q   <= '0;
      pend_q      <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      pop_rem_q   <= pop_rem_d;
      pend_q      <= issue;
      zero_done_q <= zero_done_d;
    end
  end

  assign pop = out_valid & out_ready;
  assign occ = fifo_count + CNT_W'(pend_q);

  // Next-state and read-issue logic. Issue is credit-limited so that captured
  // data always finds room: a slot is free, or the head leaves this cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    pop_rem_d   = pop_rem_q;
    zero_done_d = 1'b0;
    issue       = 1'b0;

    if (pop) begin
      pop_rem_d = pop_rem_q - LW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          rem_d     = cmd_len;
          pop_rem_d = cmd_len;
          if (cmd_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if ((rem_q != '0) &&
            ((occ < CNT_W'(FIFO_DEPTH)) || ((occ == CNT_W'(FIFO_DEPTH)) && pop))) begin
          issue = 1'b1;
        end
        if (issue) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Leave as the last buffered word goes, so busy drops right after it.
        if (!pend_q && ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef SRAM_RD_LAST_EN
  logic pend_last_q;

  // Tags the read whose data will be the final word of the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_last_q <= 1'b0;
    end else begin
      pend_last_q <= issue && (rem_q == LW'(1));
    end
  end

  assign fifo_in  = {pend_last_q, sram_dout};
  assign out_last = out_valid & fifo_head[DW];
  assign out_data = fifo_head[DW-1:0];
`else
  assign fifo_in  = sram_dout;
  assign out_data = fifo_head;
`endif

  sram_rd_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (pend_q),
    .pop_i  (pop),
    .data_i (fifo_in),
    .head_o (fifo_head),
    .count_o(fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign sram_csb  = ~issue;
  assign sram_addr = addr_q;
  assign done      = zero_done_q | (pop && (pop_rem_q == LW'(1)));

endmodule

// File: tb/tb_sram_rd_streamer.sv
// tb_sram_rd_streamer: directed bench for sram_rd_streamer with a behavioural
// SRAM read port and a scoreboard of expected words and read addresses.
module tb_sram_rd_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd_addr = '0;
  logic [8:0]  cmd_len = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        sram_csb;
  logic [7:0]  sram_addr;
  logic [31:0] sram_dout = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
`ifdef SRAM_RD_LAST_EN
  logic        out_last;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  addr_exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          inflight = 0;
  int          npop = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        zero_pend = 1'b0;

  always #5 clk = ~clk;

  sram_rd_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .sram_csb (sram_csb),
    .sram_addr(sram_addr),
    .sram_dout(sram_dout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SRAM_RD_LAST_EN
    .out_last (out_last),
`endif
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'hA500_0000 | {24'h0, a};
  endfunction

  // SRAM read port: data appears the cycle after csb is sampled low.
  always @(posedge clk) begin
    if (!sram_csb) sram_dout <= mem_word(sram_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, check everything the DUT shows this cycle.
  task automatic step(input logic rdy, input logic cv, input logic [7:0] ca, input logic [8:0] cl);
    logic pop;
    logic exp_done;
    logic zero_next;
    exp_t e;
    exp_t dropped;
    logic [7:0] a;
    @(negedge clk);
    out_ready = rdy;
    cmd_valid = cv;
    cmd_addr  = ca;
    cmd_len   = cl;
    #1;
    zero_next = 1'b0;
    pop = out_valid && out_ready;
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_data);
    end
    if (!sram_csb) begin
      if (addr_exp_q.size() == 0) begin
        chk("spurious_issue", sram_csb, 1);
      end else begin
        a = addr_exp_q.pop_front();
        chk("sram_addr", sram_addr, a);
      end
      chk("issue_credit", (inflight < 2) || ((inflight == 2) && pop), 1);
    end
    e = '0;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", out_valid, 0);
      end else begin
        e = exp_q[0];
        chk("out_data", out_data, e.d);
`ifdef SRAM_RD_LAST_EN
        chk("out_last", out_last, e.l);
`endif
        if (pop) begin
          dropped = exp_q.pop_front();
          npop++;
        end
      end
    end
    exp_done = (pop && e.l) || zero_pend;
    chk("done", done, exp_done);
    if (cv) begin
      chk("cmd_ready", cmd_ready, 1);
      for (int i = 0; i < int'(cl); i++) begin
        a = ca + 8'(i);
        addr_exp_q.push_back(a);
        exp_q.push_back('{d: mem_word(a), l: (i == int'(cl) - 1)});
      end
      zero_next = (cl == 9'd0);
    end
    inflight = inflight + (sram_csb ? 0 : 1) - (pop ? 1 : 0);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    zero_pend  = zero_next;
  endtask

  task automatic tick(input logic rdy);
    step(rdy, 1'b0, 8'h00, 9'd0);
  endtask

  // Run until the scoreboard is empty and the DUT is idle; mode picks out_ready.
  task automatic drain(input int mode);
    logic fin;
    logic rdy;
    fin = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case (mode)
        1:       rdy = ((i % 4) == 0) || ((i % 4) == 3);
        2:       rdy = ((i % 3) != 2);
        default: rdy = 1'b1;
      endcase
      tick(rdy);
      if ((exp_q.size() == 0) && (busy === 1'b0)) begin
        fin = 1'b1;
        break;
      end
    end
    chk("drain_complete", fin, 1);
    chk("addr_left", addr_exp_q.size(), 0);
  endtask

  initial begin
    int base;
    logic hit;
    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_csb", sram_csb, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // Basic burst with latency and throughput
    step(1'b1, 1'b1, 8'h10, 9'd4);
    tick(1'b1);
    chk("lat_valid_n1", out_valid, 0);
    chk("lat_busy", busy, 1);
    chk("lat_cmd_ready", cmd_ready, 0);
    tick(1'b1);
    chk("lat_valid_n2", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      chk("thru_valid", out_valid, 1);
    end
    drain(0);

    // Backpressure
    step(1'b1, 1'b1, 8'h80, 9'd8);
    drain(1);

    // Wrap-around
    step(1'b1, 1'b1, 8'hFE, 9'd4);
    drain(0);

    // Zero length
    step(1'b1, 1'b1, 8'h30, 9'd0);
    tick(1'b1);
    chk("zl_cmd_ready", cmd_ready, 1);
    chk("zl_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      chk("zl_valid", out_valid, 0);
      chk("zl_cmd_ready", cmd_ready, 1);
    end

    // Reset mid-burst
    base = npop;
    hit = 1'b0;
    step(1'b1, 1'b1, 8'h20, 9'd10);
    for (int i = 0; i < 50; i++) begin
      tick(1'b1);
      if (npop >= base + 3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("mid_reached", hit, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_csb", sram_csb, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    exp_q.delete();
    addr_exp_q.delete();
    inflight   = 0;
    prev_stall = 1'b0;
    zero_pend  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1, 8'h40, 9'd2);
    drain(0);

    // Final-word marking with a stall on the last word
    step(1'b1, 1'b1, 8'h05, 9'd3);
    drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
